// File: rtl/exu_cal.sv
// Shared calculation responder: one-cycle ALU ops and iterative 1-bit-per-cycle shifts
// behind the hs_al4cal_val / hs_cal4al_rdy request/completion handshake.
module exu_cal #(
    parameter int OPB_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hs_al4cal_val,
    output logic             hs_cal4al_rdy,
    input  logic [OPB_W-1:0] i_cal_opb,
    input  logic [32:0]      i_cal_opn1,
    input  logic [32:0]      i_cal_opn2,
    output logic [31:0]      o_cal_res
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [OPB_W-1:0] OPB_ONE = OPB_W'(1'b1);
    localparam logic [OPB_W-1:0] OPB_ADD = OPB_ONE << 0;
    localparam logic [OPB_W-1:0] OPB_SUB = OPB_ONE << 1;
    localparam logic [OPB_W-1:0] OPB_SLT = OPB_ONE << 2;
    localparam logic [OPB_W-1:0] OPB_EQ  = OPB_ONE << 3;
    localparam logic [OPB_W-1:0] OPB_XOR = OPB_ONE << 4;
    localparam logic [OPB_W-1:0] OPB_AND = OPB_ONE << 5;
    localparam logic [OPB_W-1:0] OPB_OR  = OPB_ONE << 6;
    localparam logic [OPB_W-1:0] OPB_SLL = OPB_ONE << 7;
    localparam logic [OPB_W-1:0] OPB_SRL = OPB_ONE << 8;
    localparam logic [OPB_W-1:0] OPB_SRA = OPB_ONE << 9;

    // One step of the iterative shifter; SRA keeps bit 31 so it replicates opn1[31].
    function automatic logic [31:0] shift_one(input logic [31:0] w, input logic [OPB_W-1:0] opb);
        logic [31:0] r;
        case (opb)
            OPB_SLL: r = {w[30:0], 1'b0};
            OPB_SRL: r = {1'b0, w[31:1]};
            OPB_SRA: r = {w[31], w[31:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [OPB_W-1:0] opb_r, opb_nxt_s;
    logic [31:0]      work_r, work_nxt_s;
    logic [4:0]       cnt_r, cnt_nxt_s;
    logic [31:0]      res_r, res_nxt_s;
    logic             rdy_r, rdy_nxt_s;
    logic [32:0]      sum_s, diff_s;
    logic [31:0]      alu_res_s, shift_s;
    logic             is_shift_s;

    // Single-cycle result computed straight from the request fields at acceptance.
    always_comb begin
        sum_s      = i_cal_opn1 + i_cal_opn2;
        diff_s     = i_cal_opn1 - i_cal_opn2;
        is_shift_s = (i_cal_opb == OPB_SLL) || (i_cal_opb == OPB_SRL) || (i_cal_opb == OPB_SRA);
        shift_s    = shift_one(work_r, opb_r);
        case (i_cal_opb)
            OPB_ADD: alu_res_s = sum_s[31:0];
            OPB_SUB: alu_res_s = diff_s[31:0];
            OPB_SLT: alu_res_s = {31'd0, diff_s[32]};
            OPB_EQ:  alu_res_s = {31'd0, (i_cal_opn1 == i_cal_opn2)};
            OPB_XOR: alu_res_s = i_cal_opn1[31:0] ^ i_cal_opn2[31:0];
            OPB_AND: alu_res_s = i_cal_opn1[31:0] & i_cal_opn2[31:0];
            OPB_OR:  alu_res_s = i_cal_opn1[31:0] | i_cal_opn2[31:0];
            OPB_SLL: alu_res_s = i_cal_opn1[31:0];
            OPB_SRL: alu_res_s = i_cal_opn1[31:0];
            OPB_SRA: alu_res_s = i_cal_opn1[31:0];
            default: alu_res_s = 32'd0;
        endcase
    end

    // Next-state and next-output logic; a dropped valid in SHIFT abandons the operation.
    always_comb begin
        state_nxt_s = state_r;
        opb_nxt_s   = opb_r;
        work_nxt_s  = work_r;
        cnt_nxt_s   = cnt_r;
        res_nxt_s   = res_r;
        rdy_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hs_al4cal_val) begin
                    opb_nxt_s  = i_cal_opb;
                    work_nxt_s = i_cal_opn1[31:0];
                    cnt_nxt_s  = i_cal_opn2[4:0];
                    if (is_shift_s && (i_cal_opn2[4:0] != 5'd0)) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_DONE;
                        res_nxt_s   = alu_res_s;
                        rdy_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!hs_al4cal_val) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    work_nxt_s = shift_s;
                    cnt_nxt_s  = cnt_r - 5'd1;
                    if (cnt_r == 5'd1) begin
                        state_nxt_s = ST_DONE;
                        res_nxt_s   = shift_s;
                        rdy_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            opb_r   <= '0;
            work_r  <= 32'd0;
            cnt_r   <= 5'd0;
            res_r   <= 32'd0;
            rdy_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            opb_r   <= opb_nxt_s;
            work_r  <= work_nxt_s;
            cnt_r   <= cnt_nxt_s;
            res_r   <= res_nxt_s;
            rdy_r   <= rdy_nxt_s;
        end
    end

    assign hs_cal4al_rdy = rdy_r;
    assign o_cal_res     = res_r;

endmodule
